// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline control definitions: FSM encoding, latency default
// and the per-cycle control bundle driven onto the pipeline registers.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W          = 5;
    localparam int MD_LATENCY_DEF = 4;
    localparam int MD_CNT_W       = 4;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MD_BUSY = 2'd1;
    localparam logic [1:0] ST_BR_PEND = 2'd2;

    typedef struct packed {
        logic pcwrite;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
    } ctl_t;

    localparam ctl_t CTL_RUN = '{
        pcwrite: 1'b1, ifid_we: 1'b1,
        ifid_flush: 1'b0, idex_bubble: 1'b0
    };

    localparam ctl_t CTL_STALL = '{
        pcwrite: 1'b0, ifid_we: 1'b0,
        ifid_flush: 1'b0, idex_bubble: 1'b1
    };

    // Redirect: the wrong-path fetch is squashed while the PC takes the target.
    localparam ctl_t CTL_FLUSH = '{
        pcwrite: 1'b1, ifid_we: 1'b1,
        ifid_flush: 1'b1, idex_bubble: 1'b1
    };

    localparam ctl_t CTL_RST = '{
        pcwrite: 1'b0, ifid_we: 1'b0,
        ifid_flush: 1'b1, idex_bubble: 1'b1
    };

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master)
// and the hazard controller (slave).
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);

    logic             IDEX_MemRead;
    logic [REG_W-1:0] IDEX_Rt;
    logic [REG_W-1:0] IFID_Rs;
    logic [REG_W-1:0] IFID_Rt;
    logic             Branch_Taken;
    logic             MD_Start;

    logic             PCWrite;
    logic             IFID_WriteEnable;
    logic             IFID_Flush;
    logic             IDEX_Bubble;
    logic             Busy;
    logic [CNT_W-1:0] Stall_Count;

    modport master (
        output IDEX_MemRead,
        output IDEX_Rt,
        output IFID_Rs,
        output IFID_Rt,
        output Branch_Taken,
        output MD_Start,
        input  PCWrite,
        input  IFID_WriteEnable,
        input  IFID_Flush,
        input  IDEX_Bubble,
        input  Busy,
        input  Stall_Count
    );

    modport slave (
        input  IDEX_MemRead,
        input  IDEX_Rt,
        input  IFID_Rs,
        input  IFID_Rt,
        input  Branch_Taken,
        input  MD_Start,
        output PCWrite,
        output IFID_WriteEnable,
        output IFID_Flush,
        output IDEX_Bubble,
        output Busy,
        output Stall_Count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds
// either source of the instruction in ID.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic             mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    output logic             lu_o
);

    logic rt_nonzero;
    logic src_match;

    // $zero is never really written, so a load into it cannot create a hazard.
    assign rt_nonzero = (ex_rt_i != '0);
    assign src_match  = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);
    assign lu_o       = mem_read_i && rt_nonzero && src_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and
// multi-cycle mul/div stalls, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 16
) (
    input logic                   Clock,
    input logic                   Reset,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [MD_CNT_W-1:0] MD_CNT_INIT = MD_CNT_W'(MD_LATENCY - 1);

    if (MD_LATENCY < 2 || MD_LATENCY > 15) begin : g_bad_latency
        $error("MD_LATENCY must lie in 2..15");
    end

    logic [1:0]          state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                lu;
    ctl_t                ctl;

    load_use_detect u_load_use_detect (
        .mem_read_i (hz.IDEX_MemRead),
        .ex_rt_i    (hz.IDEX_Rt),
        .id_rs_i    (hz.IFID_Rs),
        .id_rt_i    (hz.IFID_Rt),
        .lu_o       (lu)
    );

    // Branch redirect outranks a load-use stall in RUN.
    always_comb begin
        ctl = CTL_RUN;
        if (Reset) begin
            ctl = CTL_RST;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hz.Branch_Taken) begin
                        ctl = CTL_FLUSH;
                    end else if (lu) begin
                        ctl = CTL_STALL;
                    end
                end
                ST_MD_BUSY: ctl = CTL_STALL;
                ST_BR_PEND: ctl = CTL_FLUSH;
                default:    ctl = CTL_RUN;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            ST_RUN: begin
                pend_d = 1'b0;
                if (!hz.Branch_Taken && hz.MD_Start) begin
                    state_d = ST_MD_BUSY;
                    cnt_d   = MD_CNT_INIT;
                end
            end
            ST_MD_BUSY: begin
                // The redirect is deferred until the unit drains.
                pend_d = pend_q | hz.Branch_Taken;
                if (cnt_q == '0) begin
                    state_d = pend_d ? ST_BR_PEND : ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BR_PEND: begin
                state_d = ST_RUN;
                pend_d  = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (!ctl.pcwrite && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
        end
    end

    assign hz.PCWrite          = ctl.pcwrite;
    assign hz.IFID_WriteEnable = ctl.ifid_we;
    assign hz.IFID_Flush       = ctl.ifid_flush;
    assign hz.IDEX_Bubble      = ctl.idex_bubble;
    assign hz.Busy             = !Reset && (state_q == ST_MD_BUSY);
    assign hz.Stall_Count      = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl; a CNT_W=3 copy
// shares the stimulus to exercise counter saturation.
module tb_pipeline_hazard_ctrl;

    localparam logic [4:0] RUN_O = 5'b11000;
    localparam logic [4:0] STL_O = 5'b00010;
    localparam logic [4:0] BSY_O = 5'b00011;
    localparam logic [4:0] FLS_O = 5'b11110;
    localparam logic [4:0] RST_O = 5'b00110;

    typedef struct {
        logic [4:0] outs;
        int         sc;
        int         sc3;
    } exp_t;

    logic Clock;
    logic Reset;
    int   checks;
    int   errors;
    int   sc_exp;
    exp_t exp_q[$];

    pipeline_hazard_ctrl_if #(.CNT_W(16)) ifb ();
    pipeline_hazard_ctrl_if #(.CNT_W(3))  ifs ();

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .hz    (ifb.slave)
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(3)) dut3 (
        .Clock (Clock),
        .Reset (Reset),
        .hz    (ifs.slave)
    );

    assign ifs.IDEX_MemRead = ifb.IDEX_MemRead;
    assign ifs.IDEX_Rt      = ifb.IDEX_Rt;
    assign ifs.IFID_Rs      = ifb.IFID_Rs;
    assign ifs.IFID_Rt      = ifb.IFID_Rt;
    assign ifs.Branch_Taken = ifb.Branch_Taken;
    assign ifs.MD_Start     = ifb.MD_Start;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare();
        exp_t e;
        e = exp_q.pop_front();
        chk("PCWrite",          int'(ifb.PCWrite),          int'(e.outs[4]));
        chk("IFID_WriteEnable", int'(ifb.IFID_WriteEnable), int'(e.outs[3]));
        chk("IFID_Flush",       int'(ifb.IFID_Flush),       int'(e.outs[2]));
        chk("IDEX_Bubble",      int'(ifb.IDEX_Bubble),      int'(e.outs[1]));
        chk("Busy",             int'(ifb.Busy),             int'(e.outs[0]));
        chk("Stall_Count",      int'(ifb.Stall_Count),      e.sc);
        chk("Stall_Count_w3",   int'(ifs.Stall_Count),      e.sc3);
    endtask

    task automatic step(
        input logic       rst,
        input logic       mr,
        input logic [4:0] ert,
        input logic [4:0] irs,
        input logic [4:0] irt,
        input logic       br,
        input logic       md,
        input logic [4:0] outs
    );
        exp_t e;
        Reset            = rst;
        ifb.IDEX_MemRead = mr;
        ifb.IDEX_Rt      = ert;
        ifb.IFID_Rs      = irs;
        ifb.IFID_Rt      = irt;
        ifb.Branch_Taken = br;
        ifb.MD_Start     = md;
        if (rst) sc_exp = 0;
        e.outs = outs;
        e.sc   = sc_exp;
        e.sc3  = (sc_exp > 7) ? 7 : sc_exp;
        exp_q.push_back(e);
        @(negedge Clock);
        compare();
        @(posedge Clock);
        #1;
        if (!rst && !outs[4]) sc_exp++;
    endtask

    task automatic idle(input logic [4:0] outs);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, outs);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sc_exp = 0;
        Reset  = 1'b1;
        ifb.IDEX_MemRead = 1'b0;
        ifb.IDEX_Rt      = '0;
        ifb.IFID_Rs      = '0;
        ifb.IFID_Rt      = '0;
        ifb.Branch_Taken = 1'b0;
        ifb.MD_Start     = 1'b0;
        @(posedge Clock);
        #1;

        // reset hold, then first cycle after release is RUN
        step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, RST_O);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RST_O);
        idle(RUN_O);

        // load-use on Rs, then on Rt, plus non-hazard variants
        step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, STL_O);
        idle(RUN_O);
        step(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, STL_O);
        step(1'b0, 1'b1, 5'd7, 5'd3, 5'd4, 1'b0, 1'b0, RUN_O);
        step(1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, RUN_O);
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RUN_O);

        // multi-cycle op; MD_Start and LU inside MD_BUSY are ignored
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, RUN_O);
        idle(BSY_O);
        idle(BSY_O);
        step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, BSY_O);
        idle(BSY_O);
        idle(RUN_O);

        // MD_Start with LU: stall that cycle, then enter MD_BUSY
        step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, STL_O);
        idle(BSY_O);
        idle(BSY_O);
        idle(BSY_O);
        idle(BSY_O);
        idle(RUN_O);

        // branch beats LU and MD_Start
        step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, FLS_O);
        idle(RUN_O);
        idle(RUN_O);

        // branch during MD_BUSY, second branch absorbed
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, RUN_O);
        idle(BSY_O);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, BSY_O);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, BSY_O);
        idle(BSY_O);
        step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, FLS_O);
        idle(RUN_O);
        idle(RUN_O);

        // reset on MD_BUSY cycle 2
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, RUN_O);
        idle(BSY_O);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RST_O);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RST_O);
        idle(RUN_O);
        idle(RUN_O);
        idle(RUN_O);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MD_LATENCY, default 4, SHALL set the number of stall cycles per multi-cycle multiply/divide operation (legal range 2..15).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the stall performance counter.
REQ-003 Clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 IDEX_MemRead  input  1  SHALL indicate that the instruction in EX is a load.
REQ-006 IDEX_Rt  input  5  SHALL be the load destination register in EX.
REQ-007 IFID_Rs, IFID_Rt  input  5 each  SHALL be the source registers of the instruction in ID.
REQ-008 Branch_Taken  input  1  SHALL indicate a taken branch or jump resolved in EX this cycle.
REQ-009 MD_Start  input  1  SHALL indicate that a multi-cycle multiply/divide enters EX this cycle.
REQ-010 PCWrite  output  1  SHALL enable the PC register update.
REQ-011 IFID_WriteEnable  output  1  SHALL drive the IF/ID register WriteEnable.
REQ-012 IFID_Flush  output  1  SHALL drive the IF/ID register Flush.
REQ-013 IDEX_Bubble  output  1  SHALL force a NOP into ID/EX.
REQ-014 Busy  output  1  SHALL be high while the FSM is in MD_BUSY.
REQ-015 Stall_Count  output  CNT_W  SHALL be a saturating count of cycles with PCWrite=0 outside reset.

Function
REQ-016 The FSM SHALL have the states RUN, MD_BUSY and BR_PEND, plus a down-counter of 4 bits.
REQ-017 The load-use hazard LU SHALL be defined as IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==IFID_Rs || IDEX_Rt==IFID_Rt).
REQ-018 Outputs SHALL be combinational from state and inputs, with zero-cycle latency.
REQ-019 In RUN with no event, PCWrite=1, IFID_WriteEnable=1, IFID_Flush=0 and IDEX_Bubble=0.
REQ-020 In RUN with LU and !Branch_Taken, PCWrite=0, IFID_WriteEnable=0 and IDEX_Bubble=1 for that cycle; the state SHALL remain RUN.
REQ-021 In RUN with Branch_Taken, IFID_Flush=1, IDEX_Bubble=1 and PCWrite=1; Branch_Taken SHALL take priority over LU and over MD_Start.
REQ-022 In RUN with MD_Start and !Branch_Taken, the next state SHALL be MD_BUSY with the counter loaded to MD_LATENCY-1; outputs in the MD_Start cycle follow REQ-019/020.
REQ-023 In MD_BUSY, PCWrite=0, IFID_WriteEnable=0 and IDEX_Bubble=1; the counter SHALL decrement each cycle.
REQ-024 MD_BUSY SHALL exit when the counter equals 0: to BR_PEND if a branch is pending, otherwise to RUN.
REQ-025 Branch_Taken during MD_BUSY SHALL set a pending flag; a second Branch_Taken while pending SHALL be absorbed.
REQ-026 In BR_PEND, the outputs SHALL be IFID_Flush=1, IDEX_Bubble=1 and PCWrite=1 for exactly one cycle; the FSM then returns to RUN and clears the pending flag.
REQ-027 MD_Start and LU outside RUN SHALL be ignored.
REQ-028 Stall_Count SHALL increment when PCWrite=0 and SHALL hold at 2^CNT_W-1 without wrapping.

Reset
REQ-029 On Reset assertion, the state SHALL become RUN, the counter 0, the pending flag 0 and Stall_Count 0, all immediately and asynchronously.
REQ-030 While Reset is high, the outputs SHALL be PCWrite=0, IFID_WriteEnable=0, IFID_Flush=1, IDEX_Bubble=1 and Busy=0.
REQ-031 Reset during MD_BUSY or BR_PEND SHALL abort the operation with no residual flush or stall after release.
REQ-032 The first cycle after Reset deassertion SHALL behave as RUN.

Structure
REQ-033 The state encoding and the MD_LATENCY default SHALL reside in a shared pipeline control package.
REQ-034 LU detection SHALL be a combinational sub-module named load_use_detect.
REQ-035 The FSM, counter, pending flag and Stall_Count SHALL reside in pipeline_hazard_ctrl.

Verification
REQ-036 The bench SHALL cover a load-use case: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 -> one cycle of PCWrite=0, IFID_WriteEnable=0 and IDEX_Bubble=1, then RUN outputs; Stall_Count=1.
REQ-037 The bench SHALL cover load to $zero: IDEX_Rt=0=IFID_Rs -> no stall.
REQ-038 The bench SHALL cover a multi-cycle operation: MD_Start pulse -> Busy high and stall for exactly 4 cycles, RUN on cycle 5; Stall_Count=4.
REQ-039 The bench SHALL cover simultaneous events: Branch_Taken=1 together with LU=1 and MD_Start=1 -> flush cycle only, no MD_BUSY entry.
REQ-040 The bench SHALL cover a branch during a multi-cycle operation: Branch_Taken on MD_BUSY cycle 2 -> 4 stall cycles, then a 1-cycle BR_PEND flush, then RUN.
REQ-041 The bench SHALL cover reset mid-operation: Reset on MD_BUSY cycle 2 -> immediate reset outputs; RUN after release with Stall_Count=0; Stall_Count saturation checked with CNT_W=3.
